// File: rtl/eight_bit_parity_checker_pkg.sv
// Shared constants for the UART parity checker and the matching transmit-side
// parity generator.
package eight_bit_parity_checker_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/eight_bit_parity_checker_if.sv
// Received-word bus between the UART shift register (master) and the parity
// checker (slave), including the checker's diagnostic outputs.
interface eight_bit_parity_checker_if
  import eight_bit_parity_checker_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic [DATA_W:0]   data;
  logic [DATA_W-1:0] DataOut;
  logic              parity_err;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output data,
    input  DataOut,
    input  parity_err,
    input  err_cnt
  );

  modport slave (
    input  data,
    output DataOut,
    output parity_err,
    output err_cnt
  );

endinterface

// File: rtl/eight_bit_parity_checker_parity_calc.sv
// Combinational parity check over a full word, parity bit included; shared
// with the transmitter's parity generator.
module eight_bit_parity_checker_parity_calc
  import eight_bit_parity_checker_pkg::*;
#(
  parameter int WORD_W     = DATA_W_DEF + 1,
  parameter bit ODD_PARITY = PARITY_EVEN
) (
  input  logic [WORD_W-1:0] word_i,
  output logic              ok_o
);

  // Good when the XOR of every bit matches the selected mode.
  assign ok_o = ((^word_i) == ODD_PARITY);

endmodule

// File: rtl/eight_bit_parity_checker.sv
// Registered parity checker for one received UART character: forwards the
// payload when parity is good, blanks it and counts the error otherwise.
module eight_bit_parity_checker
  import eight_bit_parity_checker_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit ODD_PARITY = PARITY_EVEN,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  eight_bit_parity_checker_if.slave    bus
);

  logic              wordOk;
  logic [DATA_W-1:0] payload_d, payload_q;
  logic              parityErr_d, parityErr_q;
  logic [CNT_W-1:0]  errCnt_d, errCnt_q;

  eight_bit_parity_checker_parity_calc #(
    .WORD_W     (DATA_W + 1),
    .ODD_PARITY (ODD_PARITY)
  ) u_parity_calc (
    .word_i (bus.data),
    .ok_o   (wordOk)
  );

  // The counter saturates at all-ones so a noisy link never wraps back to a
  // misleadingly small error count.
  always_comb begin
    payload_d   = '0;
    parityErr_d = 1'b0;
    errCnt_d    = errCnt_q;
    if (wordOk) begin
      payload_d = bus.data[DATA_W-1:0];
    end else begin
      parityErr_d = 1'b1;
      if (errCnt_q != {CNT_W{1'b1}}) begin
        errCnt_d = errCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q   <= '0;
      parityErr_q <= 1'b0;
      errCnt_q    <= '0;
    end else begin
      payload_q   <= payload_d;
      parityErr_q <= parityErr_d;
      errCnt_q    <= errCnt_d;
    end
  end

  assign bus.DataOut    = payload_q;
  assign bus.parity_err = parityErr_q;
  assign bus.err_cnt    = errCnt_q;

endmodule

// File: tb/tb_eight_bit_parity_checker.sv
// Directed bench for the parity checker: reset, good/bad words, zero word,
// counter saturation, one-cycle latency and reset overriding the check.
module tb_eight_bit_parity_checker;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  eight_bit_parity_checker_if #(.DATA_W(8), .CNT_W(8)) bus ();

  eight_bit_parity_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one word for exactly one rising edge, then settle just after it.
  task automatic applyStimulus(input logic [8:0] word, input logic rstVal);
    @(negedge clk);
    bus.data = word;
    rst      = rstVal;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] expData,
                          input logic expErr, input logic [7:0] expCnt);
    checkOutput({tag, ".DataOut"},    {24'd0, bus.DataOut}, {24'd0, expData});
    checkOutput({tag, ".parity_err"}, {31'd0, bus.parity_err}, {31'd0, expErr});
    checkOutput({tag, ".err_cnt"},    {24'd0, bus.err_cnt}, {24'd0, expCnt});
  endtask

  // Hand-computed vectors: ones counts 8, 4, 6 are even (good); 9, 5 are odd.
  localparam logic [8:0] GOOD_A = 9'b110111111;
  localparam logic [8:0] GOOD_B = 9'b000001111;
  localparam logic [8:0] GOOD_C = 9'b101001111;
  localparam logic [8:0] BAD_A  = 9'b111111111;
  localparam logic [8:0] BAD_B  = 9'b100001111;

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst         = 1'b1;
    bus.data    = BAD_A;

    applyStimulus(BAD_A, 1'b1);
    applyStimulus(BAD_A, 1'b1);
    checkAll("reset", 8'h00, 1'b0, 8'd0);

    applyStimulus(GOOD_A, 1'b0);
    checkAll("goodA", 8'hBF, 1'b0, 8'd0);
    applyStimulus(GOOD_B, 1'b0);
    checkAll("goodB", 8'h0F, 1'b0, 8'd0);
    applyStimulus(GOOD_C, 1'b0);
    checkAll("goodC", 8'h4F, 1'b0, 8'd0);

    for (int i = 1; i <= 10; i++) begin
      applyStimulus(BAD_A, 1'b0);
      checkOutput("badHold.err_cnt", {24'd0, bus.err_cnt}, i);
    end
    checkAll("badHold", 8'h00, 1'b1, 8'd10);

    applyStimulus(BAD_B, 1'b0);
    checkAll("badB", 8'h00, 1'b1, 8'd11);

    applyStimulus(9'b000000000, 1'b0);
    checkAll("zeroWord", 8'h00, 1'b0, 8'd11);

    // Outputs must not follow a new word until the next rising edge.
    applyStimulus(GOOD_A, 1'b0);
    checkAll("latencyGood", 8'hBF, 1'b0, 8'd11);
    @(negedge clk);
    bus.data = BAD_A;
    #1;
    checkAll("latencyBeforeEdge", 8'hBF, 1'b0, 8'd11);
    @(posedge clk);
    #1;
    checkAll("latencyAfterEdge", 8'h00, 1'b1, 8'd12);

    applyStimulus(BAD_A, 1'b1);
    checkAll("midResetBad", 8'h00, 1'b0, 8'd0);
    applyStimulus(GOOD_A, 1'b1);
    checkAll("midResetGood", 8'h00, 1'b0, 8'd0);

    for (int i = 1; i <= 300; i++) begin
      applyStimulus(BAD_A, 1'b0);
      if (i == 254) checkOutput("sat.cnt254", {24'd0, bus.err_cnt}, 32'd254);
      if (i == 255) checkOutput("sat.cnt255", {24'd0, bus.err_cnt}, 32'd255);
      if (i == 256) checkOutput("sat.cnt256", {24'd0, bus.err_cnt}, 32'd255);
    end
    checkAll("satEnd", 8'h00, 1'b1, 8'd255);

    applyStimulus(BAD_A, 1'b1);
    checkAll("satReset", 8'h00, 1'b0, 8'd0);

    applyStimulus(GOOD_C, 1'b0);
    checkAll("afterReset", 8'h4F, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
